// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path: matrix geometry, row-index
// width, scan timer width and the scanner state encoding.
package pong_pkg;

  localparam int WIDTH   = 8;
  localparam int ROW_W   = 3;
  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_BLANK   = 2'd1,
    SCAN_DISPLAY = 2'd2
  } scan_state_e;

  function automatic logic [WIDTH-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    row_onehot      = '0;
    row_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that times the blank and dwell phases; it parks at
// zero, and done reports that the current phase is in its last cycle.
module scan_timer
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] value_q, value_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign done  = (value_q == '0);

endmodule

// File: rtl/matrix_scanner.sv
// Row-multiplexed LED matrix scanner: each row is blanked, its columns are
// latched, then it is lit for a fixed dwell before moving to the next row.
module matrix_scanner
  import pong_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [15:0]        matrix_in,
  output logic [ROW_W-1:0]   count,
  output logic [WIDTH-1:0]   row_out,
  output logic [WIDTH-1:0]   col_out,
  output logic               frame_start
);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES >= (1 << TIMER_W)) begin : g_bad_dwell
    $error("matrix_scanner: DWELL_CYCLES must be in 1..65535");
  end
  if (BLANK_CYCLES < 2 || BLANK_CYCLES >= (1 << TIMER_W)) begin : g_bad_blank
    $error("matrix_scanner: BLANK_CYCLES must be in 2..65535");
  end

  localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);

  scan_state_e        state_q, state_d;
  logic [ROW_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   cols_q, cols_d;
  logic [WIDTH-1:0]   row_out_q, row_out_d;
  logic [WIDTH-1:0]   col_out_q, col_out_d;
  logic               frame_start_q, frame_start_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic [TIMER_W-1:0] unused_timer_value;
  logic               timer_done;
  logic               unused_matrix_hi;

  assign unused_matrix_hi = ^matrix_in[15:8];

  scan_timer u_scan_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (unused_timer_value),
    .done       (timer_done)
  );

  // Outputs are computed for the next state so they change on the same edge
  // as the state; row_out is therefore dark on the edge where count moves.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    cols_d           = cols_q;
    row_out_d        = '0;
    col_out_d        = '0;
    frame_start_d    = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;

    unique case (state_q)
      SCAN_IDLE: begin
        if (enable) begin
          state_d          = SCAN_BLANK;
          timer_load       = 1'b1;
          timer_load_value = BLANK_LOAD;
          frame_start_d    = (count_q == '0);
        end
      end
      SCAN_BLANK: begin
        if (!enable) begin
          state_d = SCAN_IDLE;
        end else if (timer_done) begin
          state_d          = SCAN_DISPLAY;
          cols_d           = matrix_in[WIDTH-1:0];
          timer_load       = 1'b1;
          timer_load_value = DWELL_LOAD;
          row_out_d        = row_onehot(count_q);
          col_out_d        = matrix_in[WIDTH-1:0];
        end
      end
      SCAN_DISPLAY: begin
        if (!enable) begin
          state_d = SCAN_IDLE;
        end else if (timer_done) begin
          state_d          = SCAN_BLANK;
          count_d          = count_q + 1'b1;
          timer_load       = 1'b1;
          timer_load_value = BLANK_LOAD;
          frame_start_d    = (count_q == ROW_W'(WIDTH - 1));
        end else begin
          row_out_d = row_onehot(count_q);
          col_out_d = cols_q;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SCAN_IDLE;
      count_q       <= '0;
      cols_q        <= '0;
      row_out_q     <= '0;
      col_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      cols_q        <= cols_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign count       = count_q;
  assign row_out     = row_out_q;
  assign col_out     = col_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/matrix_scanner.md
MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000: clock cycles each row stays lit; SHALL be >= 1.
REQ-002 Parameter BLANK_CYCLES, default 4: clock cycles all rows stay dark between rows; SHALL be >= 2.
REQ-003 Port clk, input, 1 bit: single clock; every register samples on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port enable, input, 1 bit: scan enable; 1 = scan runs, 0 = display dark.
REQ-006 Port matrix_in, input, 16 bits: row pattern from game_process for the current count; [7:0] = columns 0..7, [15:8] ignored.
REQ-007 Port count, output, 3 bits: row index driven to game_process.
REQ-008 Port row_out, output, 8 bits: one-hot row drive; bit n lights row n.
REQ-009 Port col_out, output, 8 bits: column drive for the lit row.
REQ-010 Port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-011 States SHALL be IDLE, BLANK and DISPLAY.
REQ-012 IDLE: row_out=0, col_out=0, count held; exit to BLANK on the first cycle with enable=1.
REQ-013 BLANK SHALL last exactly BLANK_CYCLES cycles with row_out=0 and col_out=0.
REQ-014 On the last BLANK cycle, matrix_in[7:0] SHALL be latched into the column register; this covers the one-cycle registered latency of game_process after count changes.
REQ-015 DISPLAY SHALL last exactly DWELL_CYCLES cycles with row_out=one-hot(count) and col_out=latched columns.
REQ-016 matrix_in changes during DISPLAY SHALL NOT affect col_out.
REQ-017 DISPLAY->BLANK SHALL increment count modulo 8 (7 wraps to 0).
REQ-018 IDLE->BLANK SHALL NOT change count.
REQ-019 frame_start SHALL pulse for exactly one cycle on every entry to BLANK with count==0, including the entry from IDLE.
REQ-020 Frame period SHALL be 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-021 enable=0 in BLANK or DISPLAY SHALL force IDLE on the next edge: row_out and col_out 0 from that cycle, count unchanged, no frame_start.
REQ-022 Re-asserting enable SHALL restart the same row from the beginning of BLANK.
REQ-023 row_out SHALL never have more than one bit set.
REQ-024 row_out SHALL never be nonzero in the cycle in which count changes.
REQ-025 Dwell/blank timer SHALL be 16 bits; parameter values >= 2^16 are illegal and SHALL be flagged by an elaboration-time check.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst=1 SHALL on the next edge give: state=IDLE, count=0, row_out=0, col_out=0, frame_start=0, timer=0, column register=0.
REQ-028 rst SHALL take priority over enable and over any in-progress row, including mid-DISPLAY and mid-BLANK.

Structure
REQ-029 Shared package pong_pkg SHALL hold WIDTH=8, the row-index width (3) and the scanner state encoding; game_process and matrix_scanner SHALL both use WIDTH from it.
REQ-030 One sub-module, scan_timer, SHALL provide a loadable 16-bit down-counter with load, value and a done flag.
REQ-031 The state machine, count register and column register SHALL live in matrix_scanner.

Verification
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2.
REQ-032 Start-up: rst for 2 cycles, then enable=1, matrix_in=16'h0081 -> frame_start pulses once, count=0, 2 dark cycles, then row_out=8'h01 and col_out=8'h81 for exactly 4 cycles.
REQ-033 Full frame: enable held -> row_out sequence 01,02,04,...,80, each lit 4 cycles with 2 dark cycles between rows; frame_start period 48 cycles; count wraps 7->0.
REQ-034 Latch isolation: matrix_in changes to 16'h00FF during row 2 DISPLAY -> col_out keeps the value latched in BLANK until row 2 ends.
REQ-035 Enable drop: enable=0 in cycle 2 of row 3 DISPLAY -> next cycle row_out=0, col_out=0, count=3; enable=1 -> 2 BLANK cycles, then row 3 lit for 4 cycles.
REQ-036 Reset mid-frame: rst=1 during row 5 DISPLAY -> next cycle count=0, outputs 0, state IDLE; no frame_start until enable is seen after rst is released.
REQ-037 Checker: assertions for one-hot-or-zero row_out and for row_out=0 in every cycle in which count changes, active across all scenarios.
